// File: rtl/uart_loader_pkg.sv
// Shared types and protocol constants for the serial boot loader.
package uart_loader_pkg;

    // Parser states; every state except IDLE and RESP is inside a frame.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5,
        ST_RESP = 3'd6
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // True while a frame is partially received (the idle timeout applies).
    function automatic logic state_in_frame(input state_e s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_LEN) ||
               (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle counter: counts clocks while enabled, restarts on clear, and
// reports expired once TIMEOUT_CYCLES idle clocks have elapsed.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: zero when cleared or disabled, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader: parses host frames from the UART receiver, writes
// 32-bit words to memory, answers ACK/NAK through the UART transmitter and
// holds the CPU in reset until a RUN command arrives.
//
// Handshake semantics: rx_valid is a one-cycle strobe with rx_data valid in
// that cycle and no backpressure; tx_start is a one-cycle pulse issued only
// after tx_busy was seen low, with tx_data held stable afterwards; mem_wen
// is a one-cycle strobe qualifying mem_waddr/mem_wdata.
module uart_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  err_overrun
);

    import uart_loader_pkg::*;

    state_e                state_q, state_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  err_overrun_q, err_overrun_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;       // next word address
    logic [31:0]           shift_q, shift_d;     // LSB-first byte assembly
    logic [15:0]           len_q, len_d;         // words still to receive
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            resp_q, resp_d;       // response byte waiting in RESP

    logic        timeout_expired;
    logic [31:0] assembled;

    // Each new byte enters at the top so after four bytes the first is the LSB.
    assign assembled = {rx_data, shift_q[31:8]};

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid),
        .enable  (state_in_frame(state_q)),
        .expired (timeout_expired)
    );

    // Frame parser: next state, datapath updates and output strobes.
    always_comb begin
        state_d       = state_q;
        cpu_rst_d     = cpu_rst_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        mem_wen_d     = 1'b0;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        err_overrun_d = err_overrun_q;
        addr_d        = addr_q;
        shift_d       = shift_q;
        len_d         = len_q;
        byte_idx_d    = byte_idx_q;
        csum_d        = csum_q;
        resp_d        = resp_q;

        if (timeout_expired) begin
            // Abandon the partial frame silently.
            state_d    = ST_IDLE;
            byte_idx_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_d = ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (rx_valid) begin
                        byte_idx_d = 2'd0;
                        csum_d     = 8'd0;
                        if (rx_data == CMD_WRITE) begin
                            state_d = ST_ADDR;
                        end else if (rx_data == CMD_RUN) begin
                            cpu_rst_d = 1'b0;
                            resp_d    = RSP_ACK;
                            state_d   = ST_RESP;
                        end else begin
                            resp_d  = RSP_NAK;
                            state_d = ST_RESP;
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_valid) begin
                        csum_d     = csum_q + rx_data;
                        shift_d    = assembled;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            addr_d      = ADDR_WIDTH'(assembled);
                            addr_d[1:0] = 2'b00;
                            state_d     = ST_LEN;
                        end
                    end
                end

                ST_LEN: begin
                    if (rx_valid) begin
                        csum_d = csum_q + rx_data;
                        if (byte_idx_q == 2'd0) begin
                            len_d      = {len_q[15:8], rx_data};
                            byte_idx_d = 2'd1;
                        end else begin
                            len_d      = {rx_data, len_q[7:0]};
                            byte_idx_d = 2'd0;
                            state_d    = ({rx_data, len_q[7:0]} == 16'd0) ? ST_CSUM : ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (rx_valid) begin
                        csum_d     = csum_q + rx_data;
                        shift_d    = assembled;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            mem_wen_d   = 1'b1;
                            mem_waddr_d = addr_q;
                            mem_wdata_d = assembled;
                            addr_d      = addr_q + ADDR_WIDTH'(4);
                            len_d       = len_q - 16'd1;
                            if (len_q == 16'd1) begin
                                state_d = ST_CSUM;
                            end
                        end
                    end
                end

                ST_CSUM: begin
                    if (rx_valid) begin
                        resp_d  = (rx_data == csum_q) ? RSP_ACK : RSP_NAK;
                        state_d = ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rx_valid) begin
                        err_overrun_d = 1'b1;
                    end
                    if (!tx_busy) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = resp_q;
                        state_d    = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset holds the CPU and drops any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cpu_rst_q     <= 1'b1;
            tx_data_q     <= 8'd0;
            tx_start_q    <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= 32'd0;
            err_overrun_q <= 1'b0;
            addr_q        <= '0;
            shift_q       <= 32'd0;
            len_q         <= 16'd0;
            byte_idx_q    <= 2'd0;
            csum_q        <= 8'd0;
            resp_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            cpu_rst_q     <= cpu_rst_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            mem_wen_q     <= mem_wen_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wdata_q   <= mem_wdata_d;
            err_overrun_q <= err_overrun_d;
            addr_q        <= addr_d;
            shift_q       <= shift_d;
            len_q         <= len_d;
            byte_idx_q    <= byte_idx_d;
            csum_q        <= csum_d;
            resp_q        <= resp_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign mem_wen     = mem_wen_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a frame-level reference model.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        err_overrun;

    int checks = 0;
    int failures = 0;

    // Model state and expectations.
    logic [7:0]  frm[$];
    logic [63:0] exp_wr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        exp_cpu_rst = 1'b1;
    logic        exp_overrun = 1'b0;

    // What the DUT was observed to do.
    logic [63:0] obs_wr[$];
    logic [7:0]  obs_tx[$];
    logic        prev_busy = 1'b0;

    logic [7:0]  fb[$];

    uart_loader #(
        .TIMEOUT_CYCLES(16),
        .ADDR_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .cpu_rst     (cpu_rst),
        .err_overrun (err_overrun)
    );

    // Clock.
    always #5 clk = ~clk;

    // Frame-level model: collect bytes of the current frame and derive
    // writes and responses from byte positions within it.
    task automatic model_byte(input logic [7:0] b);
        int n;
        int len;
        int k;
        logic [31:0] a;
        logic [7:0] s;
        if (frm.size() == 0 && b != 8'hA5) return;
        frm.push_back(b);
        n = frm.size();
        if (n == 2) begin
            if (b == 8'h02) begin
                exp_cpu_rst = 1'b0;
                exp_tx_q.push_back(8'h06);
                frm.delete();
            end else if (b != 8'h01) begin
                exp_tx_q.push_back(8'h15);
                frm.delete();
            end
            return;
        end
        if (n < 8) return;
        len = int'({frm[7], frm[6]});
        a = {frm[5], frm[4], frm[3], frm[2]} & ~32'h3;
        if (n > 8 && n <= 8 + 4 * len && ((n - 8) % 4) == 0) begin
            k = (n - 8) / 4 - 1;
            exp_wr_q.push_back({a + 32'(k * 4), frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
        end
        if (n == 9 + 4 * len) begin
            s = 8'd0;
            for (int i = 2; i < n - 1; i++) s = s + frm[i];
            exp_tx_q.push_back((s == b) ? 8'h06 : 8'h15);
            frm.delete();
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: one byte strobe, then the model sees it after the DUT sampled it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        model_byte(b);
        repeat (gap) @(posedge clk);
    endtask

    // Byte sent while the DUT is holding a response: dropped, flags overrun.
    task automatic inject_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        exp_overrun = 1'b1;
    endtask

    task automatic send_frame(input int gap);
        foreach (fb[i]) send_byte(fb[i], gap);
    endtask

    task automatic wait_resp(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            if (obs_tx.size() > 0) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s: no tx_start within %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_tx.delete();
    endtask

    // Scoreboard: every cycle out of reset, compare DUT outputs with the model.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [7:0]  t;
        if (!rst) begin
            checks++;
            if (cpu_rst !== exp_cpu_rst) begin
                failures++;
                $display("FAIL cpu_rst: got %b expected %b at %0t", cpu_rst, exp_cpu_rst, $time);
            end
            checks++;
            if (err_overrun !== exp_overrun) begin
                failures++;
                $display("FAIL err_overrun: got %b expected %b at %0t", err_overrun, exp_overrun, $time);
            end
            if (mem_wen) begin
                obs_wr.push_back({mem_waddr, mem_wdata});
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL write: unexpected addr %h data %h", mem_waddr, mem_wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({mem_waddr, mem_wdata} !== e) begin
                        failures++;
                        $display("FAIL write: got addr %h data %h expected addr %h data %h",
                                 mem_waddr, mem_wdata, e[63:32], e[31:0]);
                    end
                end
            end
            if (tx_start) begin
                obs_tx.push_back(tx_data);
                checks++;
                if (prev_busy) begin
                    failures++;
                    $display("FAIL tx_busy: tx_start issued while transmitter busy");
                end
                checks++;
                if (exp_tx_q.size() == 0) begin
                    failures++;
                    $display("FAIL response: unexpected tx_data %h", tx_data);
                end else begin
                    t = exp_tx_q.pop_front();
                    if (tx_data !== t) begin
                        failures++;
                        $display("FAIL response: got %h expected %h", tx_data, t);
                    end
                end
            end
        end
        prev_busy = tx_busy;
    end

    // Stimulus.
    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("reset_tx_data", 64'(tx_data), 64'd0);
        chk("reset_mem_waddr", 64'(mem_waddr), 64'd0);
        chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        chk("idle_no_write", 64'(obs_wr.size()), 64'd0);
        chk("idle_no_tx", 64'(obs_tx.size()), 64'd0);
        chk("idle_overrun", 64'(err_overrun), 64'd0);

        // Stray byte in IDLE, then a one-word write with good checksum.
        clear_obs();
        send_byte(8'h3C, 2);
        fb = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h49};
        send_frame(2);
        wait_resp("write_ack", 20);
        chk("write_ack_count", 64'(obs_wr.size()), 64'd1);
        chk("write_ack_word", obs_wr[0], 64'h00000010_DEADBEEF);
        chk("write_ack_tx", 64'(obs_tx[0]), 64'h06);

        // Same frame, bad checksum: word still written, NAK.
        clear_obs();
        fb[12] = 8'h48;
        send_frame(1);
        wait_resp("write_nak", 20);
        chk("write_nak_word", obs_wr[0], 64'h00000010_DEADBEEF);
        chk("write_nak_tx", 64'(obs_tx[0]), 64'h15);

        // Unaligned address is forced down to a word boundary.
        clear_obs();
        fb = '{8'hA5, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h2E};
        send_frame(3);
        wait_resp("align", 20);
        chk("align_word", obs_wr[0], 64'h00000020_04030201);
        chk("align_tx", 64'(obs_tx[0]), 64'h06);

        // Zero-length write goes straight to the checksum.
        clear_obs();
        fb = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20};
        send_frame(2);
        wait_resp("len0", 20);
        chk("len0_no_write", 64'(obs_wr.size()), 64'd0);
        chk("len0_tx", 64'(obs_tx[0]), 64'h06);

        // Address wrap across the top of memory.
        clear_obs();
        fb = '{8'hA5, 8'h01, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h5F};
        send_frame(2);
        wait_resp("wrap", 20);
        chk("wrap_count", 64'(obs_wr.size()), 64'd2);
        chk("wrap_word0", obs_wr[0], 64'hFFFFFFFC_44332211);
        chk("wrap_word1", obs_wr[1], 64'h00000000_88776655);
        chk("wrap_tx", 64'(obs_tx[0]), 64'h06);

        // RUN while the transmitter is busy for 50 cycles.
        clear_obs();
        @(posedge clk); #1;
        tx_busy = 1'b1;
        fb = '{8'hA5, 8'h02};
        send_frame(0);
        chk("run_cpu_rst", 64'(cpu_rst), 64'd0);
        repeat (50) @(posedge clk);
        chk("run_held_by_busy", 64'(obs_tx.size()), 64'd0);
        #1;
        tx_busy = 1'b0;
        wait_resp("run", 20);
        chk("run_tx", 64'(obs_tx[0]), 64'h06);

        // RUN again: plain ACK.
        clear_obs();
        send_frame(2);
        wait_resp("run_again", 20);
        chk("run_again_tx", 64'(obs_tx[0]), 64'h06);

        // Timeout after the third data byte: nothing written, no response.
        clear_obs();
        fb = '{8'hA5, 8'h01, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33};
        send_frame(2);
        frm.delete();
        repeat (20) @(posedge clk);
        chk("timeout_no_write", 64'(obs_wr.size()), 64'd0);
        chk("timeout_no_tx", 64'(obs_tx.size()), 64'd0);
        fb = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h49};
        send_frame(1);
        wait_resp("after_timeout", 20);
        chk("after_timeout_word", obs_wr[0], 64'h00000010_DEADBEEF);
        chk("after_timeout_tx", 64'(obs_tx[0]), 64'h06);

        // Unknown command.
        clear_obs();
        fb = '{8'hA5, 8'h07};
        send_frame(2);
        wait_resp("bad_cmd", 20);
        chk("bad_cmd_tx", 64'(obs_tx[0]), 64'h15);

        // Byte arriving while the NAK waits on a busy transmitter.
        clear_obs();
        @(posedge clk); #1;
        tx_busy = 1'b1;
        send_frame(0);
        repeat (3) @(posedge clk);
        inject_byte(8'hA5);
        chk("overrun_flag", 64'(err_overrun), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        tx_busy = 1'b0;
        wait_resp("overrun", 20);
        chk("overrun_tx", 64'(obs_tx[0]), 64'h15);
        chk("overrun_sticky", 64'(err_overrun), 64'd1);

        // Reset mid-frame re-asserts cpu_rst and clears the sticky flag.
        clear_obs();
        fb = '{8'hA5, 8'h01, 8'h10};
        send_frame(1);
        @(posedge clk); #1;
        rst = 1'b1;
        frm.delete();
        exp_cpu_rst = 1'b1;
        exp_overrun = 1'b0;
        #2;
        chk("midreset_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("midreset_overrun", 64'(err_overrun), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fb = '{8'hA5, 8'h02};
        send_frame(2);
        wait_resp("post_reset_run", 20);
        chk("post_reset_run_tx", 64'(obs_tx[0]), 64'h06);
        chk("post_reset_no_write", 64'(obs_wr.size()), 64'd0);

        // Everything predicted must have been seen.
        chk("pending_writes", 64'(exp_wr_q.size()), 64'd0);
        chk("pending_responses", 64'(exp_tx_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
